// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier issue/collect stage.
package booth_pkg;

  localparam int BOOTH_N       = 8;
  localparam int BOOTH_DEPTH   = 4;
  localparam int BOOTH_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    CAPT  = 3'd4
  } state_t;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int booth_pend_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int BOOTH_PEND_W = booth_pend_w(BOOTH_DEPTH);

endpackage

// File: rtl/booth_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, occupancy counter.
module booth_op_fifo
  import booth_pkg::*;
#(
  parameter int W     = 2 * BOOTH_N,
  parameter int DEPTH = BOOTH_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [W-1:0]                    wdata,
  output logic [W-1:0]                    rdata,
  output logic                            full,
  output logic                            empty,
  output logic [booth_pend_w(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = booth_pend_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/booth_issue.sv
// Issues queued operand pairs to an external sequential Booth multiplier one at
// a time, collects each product, and guards the handshake with a watchdog.
//
// state | meaning
// IDLE  | wait for a queued pair and a free output register, then pop it
// ISSUE | start pulse to the multiplier
// ARM   | wait for busy to rise
// RUN   | wait for busy to fall; product captured on leaving
// CAPT  | product presented, return to IDLE
module booth_issue
  import booth_pkg::*;
#(
  parameter int n       = BOOTH_N,
  parameter int DEPTH   = BOOTH_DEPTH,
  parameter int TIMEOUT = BOOTH_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [n-1:0]                    in_a,
  input  logic [n-1:0]                    in_b,
  output logic [n-1:0]                    op1,
  output logic [n-1:0]                    op2,
  output logic                            start,
  input  logic                            busy,
  input  logic [2*n-1:0]                  o,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*n-1:0]                  out_p,
  output logic [booth_pend_w(DEPTH)-1:0]  pending,
  output logic                            err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic            pop;
  logic            capture;
  logic            wd_fire;
  logic            timeout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [2*n-1:0]  head;
  logic [WD_W-1:0] wd;

  booth_op_fifo #(
    .W     (2 * n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  assign in_ready = !fifo_full;
  assign start    = (state == ISSUE);
  assign timeout  = ((state == ARM) || (state == RUN)) && (wd == '0);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    wd_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !out_valid) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = ARM;
      ARM: begin
        if (busy) begin
          state_nx = RUN;
        end else if (timeout) begin
          wd_fire  = 1'b1;
          state_nx = IDLE;
        end
      end
      RUN: begin
        // Latch on the edge that sees busy low so out_valid is up during CAPT.
        if (!busy) begin
          capture  = 1'b1;
          state_nx = CAPT;
        end else if (timeout) begin
          wd_fire  = 1'b1;
          state_nx = IDLE;
        end
      end
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op1       <= '0;
      op2       <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      err       <= 1'b0;
      wd        <= WD_LOAD;
    end else begin
      state <= state_nx;
      if (pop) begin
        op1 <= head[2*n-1:n];
        op2 <= head[n-1:0];
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_p     <= o;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wd_fire) err <= 1'b1;
      // Watchdog reloads on every state change and counts down while waiting.
      if (state_nx != state) begin
        wd <= WD_LOAD;
      end else if (wd != '0) begin
        wd <= wd - 1'b1;
      end
    end
  end

endmodule
